// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter.
//   t_arb_state : arbiter FSM states
//   t_requester : which cache owns / last owned the port
//   line_base() : clears the in-line offset bits of a byte address
package mem_arb_pkg;

  typedef enum logic [2:0] {IDLE, IC_RD, DC_RD, DC_WR, DONE} t_arb_state;
  typedef enum logic {REQ_IC, REQ_DC} t_requester;

  function automatic logic [63:0] line_base(input logic [63:0] addr,
                                            input int unsigned off_bits);
    return addr & ~((64'd1 << off_bits) - 64'd1);
  endfunction

endpackage

// File: rtl/mem_arb_beat_ctr.sv
// Beat counter and beat address generator for one cache-line burst.
//   clk, arstn : clock, async active-low reset
//   load       : capture the line base for the next burst
//   base       : line base address (offset bits already cleared)
//   advance    : current beat completed
//   clear      : return the counter to beat 0
//   last       : current beat is the final beat of the line
//   addr       : byte address of the current beat
module mem_arb_beat_ctr #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int BEATS      = 16
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic                  advance,
  input  logic                  clear,
  output logic                  last,
  output logic [ADDR_WIDTH-1:0] addr
);
  import mem_arb_pkg::*;

  localparam int CNT_W     = $clog2(BEATS);
  localparam int STRIDE_SH = $clog2(DATA_WIDTH / 8);

  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] base_q;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cnt    <= '0;
      base_q <= '0;
    end else begin
      if (load) base_q <= base;
      if (clear)        cnt <= '0;
      else if (advance) cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(BEATS - 1));
  assign addr = base_q + (ADDR_WIDTH'(cnt) << STRIDE_SH);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of one external memory port between I-cache refills,
// D-cache refills and D-cache writebacks; each grant runs a full BEATS burst.
// Optional feature macro: MEM_ARB_TIMEOUT_EN (per-beat watchdog, o_err pulse).
// Ports:
//   clk, arstn                      clock, async active-low reset
//   i_ic_req/i_ic_addr              I-cache line read request
//   o_ic_grant/rdata/rvalid/done    I-cache response side
//   i_dc_req/we/addr/wdata          D-cache refill or writeback request
//   o_dc_grant/rdata/rvalid/wready/done  D-cache response side
//   o_mem_req/we/addr/wdata         beat request to memory
//   i_mem_ready/i_mem_rdata         beat completion and read data
//   o_err                           watchdog abort, coincident with done
module mem_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int BEATS      = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  i_ic_req,
  input  logic [ADDR_WIDTH-1:0] i_ic_addr,
  output logic                  o_ic_grant,
  output logic [DATA_WIDTH-1:0] o_ic_rdata,
  output logic                  o_ic_rvalid,
  output logic                  o_ic_done,
  input  logic                  i_dc_req,
  input  logic                  i_dc_we,
  input  logic [ADDR_WIDTH-1:0] i_dc_addr,
  input  logic [DATA_WIDTH-1:0] i_dc_wdata,
  output logic                  o_dc_grant,
  output logic [DATA_WIDTH-1:0] o_dc_rdata,
  output logic                  o_dc_rvalid,
  output logic                  o_dc_wready,
  output logic                  o_dc_done,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_ready,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_err
);
  import mem_arb_pkg::*;

  localparam int OFF_BITS = $clog2(BEATS * DATA_WIDTH / 8);

  t_arb_state state;
  t_requester owner, last_grant, pick;
  logic ic_grant, dc_grant, mem_req, mem_we, ic_done, dc_done, err;
  logic tie, load, last, wd_fire;
  logic [ADDR_WIDTH-1:0] sel_addr, base, beat_addr;

  // Round-robin: on a tie the requester that did not win the previous tie goes.
  assign tie = i_ic_req && i_dc_req;
  always_comb begin
    pick = REQ_IC;
    if (tie)           pick = (last_grant == REQ_IC) ? REQ_DC : REQ_IC;
    else if (i_dc_req) pick = REQ_DC;
  end

  assign sel_addr = (pick == REQ_DC) ? i_dc_addr : i_ic_addr;
  assign base     = ADDR_WIDTH'(line_base(64'(sel_addr), OFF_BITS));
  assign load     = (state == IDLE) && (i_ic_req || i_dc_req);

  mem_arb_beat_ctr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BEATS      (BEATS)
  ) u_beat_ctr (
    .clk     (clk),
    .arstn   (arstn),
    .load    (load),
    .base    (base),
    .advance (mem_req && i_mem_ready),
    .clear   ((state == DONE) || wd_fire),
    .last    (last),
    .addr    (beat_addr)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  // Counts consecutive not-ready cycles of the current beat; idle/grant
  // cycles have mem_req low, so each burst starts from zero.
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)                     wd <= '0;
    else if (!mem_req || i_mem_ready) wd <= '0;
    else                            wd <= wd + WD_W'(1);
  end

  // Firing on the TIMEOUT-th stalled cycle lands DONE right when the count
  // would have reached TIMEOUT.
  assign wd_fire = mem_req && !i_mem_ready && (wd == WD_W'(TIMEOUT - 1));
`else
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state      <= IDLE;
      owner      <= REQ_IC;
      last_grant <= REQ_IC;
      ic_grant   <= 1'b0;
      dc_grant   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      ic_done    <= 1'b0;
      dc_done    <= 1'b0;
      err        <= 1'b0;
    end else begin
      ic_done <= 1'b0;
      dc_done <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (i_ic_req || i_dc_req) begin
            owner   <= pick;
            mem_req <= 1'b1;
            if (tie) last_grant <= pick;
            if (pick == REQ_IC) begin
              state    <= IC_RD;
              ic_grant <= 1'b1;
            end else begin
              state    <= i_dc_we ? DC_WR : DC_RD;
              dc_grant <= 1'b1;
              mem_we   <= i_dc_we;
            end
          end
        end
        IC_RD, DC_RD, DC_WR: begin
          if (wd_fire || (i_mem_ready && last)) begin
            state   <= DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err     <= wd_fire;
            if (owner == REQ_IC) ic_done <= 1'b1;
            else                 dc_done <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          ic_grant <= 1'b0;
          dc_grant <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_ic_grant  = ic_grant;
  assign o_dc_grant  = dc_grant;
  assign o_ic_done   = ic_done;
  assign o_dc_done   = dc_done;
  assign o_err       = err;
  assign o_mem_req   = mem_req;
  assign o_mem_we    = mem_we;
  assign o_mem_addr  = mem_req ? beat_addr : '0;
  assign o_mem_wdata = mem_we ? i_dc_wdata : '0;

  // Beat handshakes are combinational on ready: the beat completes this cycle.
  assign o_ic_rvalid = (state == IC_RD) && i_mem_ready;
  assign o_dc_rvalid = (state == DC_RD) && i_mem_ready;
  assign o_dc_wready = (state == DC_WR) && i_mem_ready;
  assign o_ic_rdata  = (state == IC_RD) ? i_mem_rdata : '0;
  assign o_dc_rdata  = (state == DC_RD) ? i_mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (BEATS=4, DW=32, AW=64, TIMEOUT=8).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0, ready = 1'b0;
  logic [63:0] ic_addr = '0, dc_addr = '0;
  logic [31:0] dc_wdata = '0, mem_rdata = '0;

  logic        o_ic_grant, o_ic_rvalid, o_ic_done;
  logic        o_dc_grant, o_dc_rvalid, o_dc_wready, o_dc_done;
  logic        o_mem_req, o_mem_we, o_err;
  logic [31:0] o_ic_rdata, o_dc_rdata, o_mem_wdata;
  logic [63:0] o_mem_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(32), .BEATS(4), .TIMEOUT(8)) dut (
    .clk(clk), .arstn(arstn),
    .i_ic_req(ic_req), .i_ic_addr(ic_addr),
    .o_ic_grant(o_ic_grant), .o_ic_rdata(o_ic_rdata), .o_ic_rvalid(o_ic_rvalid),
    .o_ic_done(o_ic_done),
    .i_dc_req(dc_req), .i_dc_we(dc_we), .i_dc_addr(dc_addr), .i_dc_wdata(dc_wdata),
    .o_dc_grant(o_dc_grant), .o_dc_rdata(o_dc_rdata), .o_dc_rvalid(o_dc_rvalid),
    .o_dc_wready(o_dc_wready), .o_dc_done(o_dc_done),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ready(ready), .i_mem_rdata(mem_rdata),
    .o_err(o_err)
  );

  // in = {ic_req, dc_req, dc_we, ready}; g = {ic_grant, dc_grant, mem_req, mem_we}
  // f = {ic_rvalid, dc_rvalid, dc_wready, ic_done, dc_done}; o_err expected 0
  typedef struct {
    logic [3:0]  in;
    logic [63:0] ia, da;
    logic [31:0] wd;
    logic [3:0]  g;
    logic [63:0] ea;
    logic [31:0] ew;
    logic [4:0]  f;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [3:0] in, input logic [63:0] ia, da,
                              input logic [31:0] wd, input logic [3:0] g,
                              input logic [63:0] ea, input logic [31:0] ew,
                              input logic [4:0] f);
    vec_t v;
    v.in = in; v.ia = ia; v.da = da; v.wd = wd;
    v.g = g; v.ea = ea; v.ew = ew; v.f = f;
    return v;
  endfunction

  function automatic logic [105:0] outs();
    return {o_ic_grant, o_dc_grant, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
            o_ic_rvalid, o_dc_rvalid, o_dc_wready, o_ic_done, o_dc_done, o_err};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_done(input logic is_ic, input string tag);
    bit seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (is_ic ? o_ic_done : o_dc_done) seen = 1;
    end
    chk({tag, "_done_seen"}, 128'(seen), 128'(1));
    if (is_ic) ic_req = 1'b0;
    else begin dc_req = 1'b0; dc_we = 1'b0; end
  endtask

  // One burst with 0-5 cycle random stalls per beat; requester advances its
  // write word only after wready.
  task automatic stall_burst(input logic is_ic, input logic we, input logic [63:0] a,
                             input string tag);
    logic [31:0] words [4];
    logic [63:0] base;
    logic [2:0]  exp_ack;
    int beat = 0, stall, cyc = 0;
    bit seen = 0;
    base = a & ~64'hF;
    for (int i = 0; i < 4; i++) words[i] = 32'hC0DE_0000 + 32'(i * 17) + (is_ic ? 32'h100 : 32'h0);
    @(negedge clk);
    ready = 1'b0;
    if (is_ic) begin ic_req = 1'b1; ic_addr = a; end
    else begin dc_req = 1'b1; dc_we = we; dc_addr = a; dc_wdata = words[0]; end
    stall = $urandom_range(0, 5);
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (o_mem_req) begin
        if (we) dc_wdata = words[beat & 3];
        if (stall > 0) begin ready = 1'b0; stall--; end
        else begin ready = 1'b1; mem_rdata = words[beat & 3]; end
        #1;
        chk({tag, "_addr"}, 128'(o_mem_addr), 128'(base + 64'(beat * 4)));
        if (we) chk({tag, "_wdata"}, 128'(o_mem_wdata), 128'(words[beat & 3]));
        exp_ack = !ready ? 3'b000 : (is_ic ? 3'b100 : (we ? 3'b001 : 3'b010));
        chk({tag, "_ack"}, 128'({o_ic_rvalid, o_dc_rvalid, o_dc_wready}), 128'(exp_ack));
        if (ready && is_ic) chk({tag, "_rdata"}, 128'(o_ic_rdata), 128'(words[beat & 3]));
        if (ready) begin beat++; stall = $urandom_range(0, 5); end
      end else if (o_ic_done || o_dc_done) begin
        seen = 1;
        chk({tag, "_beats"}, 128'(beat), 128'(4));
        chk({tag, "_done_owner"}, 128'({o_ic_done, o_dc_done}), 128'(is_ic ? 2'b10 : 2'b01));
        ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0; ready = 1'b0;
      end
    end
    chk({tag, "_completed"}, 128'(seen), 128'(1));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // 1: IC refill, addr 0x1008
    vq.push_back(mk(4'b1001, 64'h1008, 0, 0, 4'b0000, 0, 0, 5'b00000));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(4'b1001, 64'h1008, 0, 0, 4'b1010, 64'h1000 + 64'(4 * i), 0, 5'b10000));
    vq.push_back(mk(4'b0000, 64'h1008, 0, 0, 4'b1000, 0, 0, 5'b00010));
    vq.push_back(mk(4'b0000, 64'h1008, 0, 0, 4'b0000, 0, 0, 5'b00000));
    // 2: tie after reset -> DC first, then IC; next tie -> IC first, then DC
    vq.push_back(mk(4'b1101, 64'h1008, 64'h301C, 0, 4'b0000, 0, 0, 5'b00000));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(4'b1101, 64'h1008, 64'h301C, 0, 4'b0110, 64'h3010 + 64'(4 * i), 0, 5'b01000));
    vq.push_back(mk(4'b1001, 64'h1008, 64'h301C, 0, 4'b0100, 0, 0, 5'b00001));
    vq.push_back(mk(4'b1001, 64'h1008, 64'h301C, 0, 4'b0000, 0, 0, 5'b00000));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(4'b1001, 64'h1008, 64'h301C, 0, 4'b1010, 64'h1000 + 64'(4 * i), 0, 5'b10000));
    vq.push_back(mk(4'b0001, 64'h1008, 64'h301C, 0, 4'b1000, 0, 0, 5'b00010));
    vq.push_back(mk(4'b1101, 64'h1008, 64'h301C, 0, 4'b0000, 0, 0, 5'b00000));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(4'b1101, 64'h1008, 64'h301C, 0, 4'b1010, 64'h1000 + 64'(4 * i), 0, 5'b10000));
    vq.push_back(mk(4'b0101, 64'h1008, 64'h301C, 0, 4'b1000, 0, 0, 5'b00010));
    vq.push_back(mk(4'b0101, 64'h1008, 64'h301C, 0, 4'b0000, 0, 0, 5'b00000));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(4'b0101, 64'h1008, 64'h301C, 0, 4'b0110, 64'h3010 + 64'(4 * i), 0, 5'b01000));
    vq.push_back(mk(4'b0001, 64'h1008, 64'h301C, 0, 4'b0100, 0, 0, 5'b00001));
    vq.push_back(mk(4'b0000, 64'h1008, 64'h301C, 0, 4'b0000, 0, 0, 5'b00000));
    // 3: DC writeback at 0x2004, words A0..A3
    vq.push_back(mk(4'b0111, 64'h1008, 64'h2004, 32'hA0A0_0000, 4'b0000, 0, 0, 5'b00000));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(4'b0111, 64'h1008, 64'h2004, 32'hA0A0_0000 + 32'(i), 4'b0111,
                      64'h2000 + 64'(4 * i), 32'hA0A0_0000 + 32'(i), 5'b00100));
    vq.push_back(mk(4'b0001, 64'h1008, 64'h2004, 0, 4'b0100, 0, 0, 5'b00001));
    vq.push_back(mk(4'b0000, 64'h1008, 64'h2004, 0, 4'b0000, 0, 0, 5'b00000));

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", 128'(outs()), 128'(0));
    chk("reset_rdata", 128'({o_ic_rdata, o_dc_rdata}), 128'(0));
    arstn = 1'b1;

    for (int k = 0; k < vq.size(); k++) begin
      @(posedge clk);
      #1;
      {ic_req, dc_req, dc_we, ready} = vq[k].in;
      ic_addr = vq[k].ia;
      dc_addr = vq[k].da;
      dc_wdata = vq[k].wd;
      mem_rdata = 32'hD000_0000 + 32'(k);
      @(negedge clk);
      chk($sformatf("vec%0d", k), 128'(outs()),
          128'({vq[k].g, vq[k].ea, vq[k].ew, vq[k].f, 1'b0}));
      if (vq[k].f[4]) chk($sformatf("vec%0d_ic_rdata", k), 128'(o_ic_rdata), 128'(mem_rdata));
      if (vq[k].f[3]) chk($sformatf("vec%0d_dc_rdata", k), 128'(o_dc_rdata), 128'(mem_rdata));
    end

    // 4: random stalls
    stall_burst(1'b0, 1'b1, 64'h6008, "stall_wr");
    stall_burst(1'b1, 1'b0, 64'h7034, "stall_ic");
    stall_burst(1'b0, 1'b0, 64'h8010, "stall_dcrd");

    // 5: async reset during beat 2 of a DC refill, then tie goes to DC again
    @(negedge clk);
    ic_req = 1'b1; dc_req = 1'b1; dc_we = 1'b0; dc_addr = 64'h4000; ic_addr = 64'h1000; ready = 1'b1;
    @(negedge clk);
    chk("pre_rst_tie_grant", 128'({o_ic_grant, o_dc_grant}), 128'(2'b01));
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_beat2_addr", 128'(o_mem_addr), 128'(64'h4008));
    #2 arstn = 1'b0;
    #1;
    chk("async_rst_outputs", 128'(outs()), 128'(0));
    chk("async_rst_rdata", 128'({o_ic_rdata, o_dc_rdata}), 128'(0));
    ic_req = 1'b0; dc_req = 1'b0; ready = 1'b0;
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 128'(outs()), 128'(0));
    ic_req = 1'b1; dc_req = 1'b1; ready = 1'b1;
    @(negedge clk);
    chk("post_rst_tie_grant", 128'({o_ic_grant, o_dc_grant}), 128'(2'b01));
    wait_done(1'b0, "post_rst_dc");
    wait_done(1'b1, "post_rst_ic");
    ready = 1'b0;
    @(negedge clk);

    // 6: memory never ready
`ifdef MEM_ARB_TIMEOUT_EN
    begin
      int n = 0;
      bit seen = 0;
      dc_req = 1'b1; dc_we = 1'b0; dc_addr = 64'h5000;
      for (int c = 0; c < 50 && !seen; c++) begin
        @(negedge clk);
        if (o_mem_req) n++;
        if (o_dc_done) begin
          seen = 1;
          chk("timeout_err_done", 128'({o_err, o_dc_done, o_mem_req}), 128'(3'b110));
          dc_req = 1'b0;
        end
      end
      chk("timeout_seen", 128'(seen), 128'(1));
      chk("timeout_cycles", 128'(n), 128'(8));
      @(negedge clk);
      chk("timeout_idle", 128'({o_dc_grant, o_mem_req, o_err}), 128'(0));
    end
`else
    begin
      int bad = 0;
      dc_req = 1'b1; dc_we = 1'b0; dc_addr = 64'h5000;
      @(negedge clk);
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (!o_mem_req || o_err || o_mem_addr != 64'h5000) bad++;
      end
      chk("no_timeout_hold", 128'(bad), 128'(0));
      ready = 1'b1;
      wait_done(1'b0, "no_timeout");
      ready = 1'b0;
      @(negedge clk);
      chk("no_timeout_idle", 128'(outs()), 128'(0));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
